// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, with start/busy/done handshake.
// Outputs are registered from the FSM state, so busy/done trail the internal state by one clock.
module serial_addsub_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   result_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic sum_bit(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic maj_bit(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, sub_q, sub_d, msb_q, msb_d, ovf_q, ovf_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             overflow_q, overflow_d, busy_q, busy_d, done_q, done_d;
    logic             sum_s, cout_s, load_s;
    logic [WIDTH-1:0] shb_load_s;

    assign sum_s      = sum_bit(sha_q[0], shb_q[0], carry_q);
    assign cout_s     = maj_bit(sha_q[0], shb_q[0], carry_q);
    assign shb_load_s = sub_i ? ~b_i : b_i;
    assign load_s     = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and datapath update for one serial step.
    always_comb begin
        state_d    = state_q;
        sha_d      = sha_q;
        shb_d      = shb_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        sub_d      = sub_q;
        msb_d      = msb_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        busy_d     = (state_q == ST_SHIFT);
        done_d     = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                sha_d   = {1'b0, sha_q[WIDTH-1:1]};
                shb_d   = {1'b0, shb_q[WIDTH-1:1]};
                res_d   = {sum_s, res_q[WIDTH-1:1]};
                carry_d = cout_s;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_ZERO) begin
                    // carry_q here is the carry into the MSB
                    msb_d   = cout_s ^ sub_q;
                    ovf_d   = carry_q ^ cout_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                result_d   = {msb_q, res_q};
                overflow_d = ovf_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            state_d = ST_SHIFT;
            sha_d   = a_i;
            shb_d   = shb_load_s;
            sub_d   = sub_i;
            carry_d = sub_i;
            cnt_d   = CNT_LAST;
            res_d   = {WIDTH{1'b0}};
        end else begin
            sub_d = sub_q;
        end
    end

    // State registers with synchronous reset that discards any partial result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sha_q      <= {WIDTH{1'b0}};
            shb_q      <= {WIDTH{1'b0}};
            res_q      <= {WIDTH{1'b0}};
            cnt_q      <= CNT_ZERO;
            carry_q    <= 1'b0;
            sub_q      <= 1'b0;
            msb_q      <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= {(WIDTH + 1){1'b0}};
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sha_q      <= sha_d;
            shb_q      <= shb_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            sub_q      <= sub_d;
            msb_q      <= msb_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign result_o   = result_q;
    assign overflow_o = overflow_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Directed self-checking bench for serial_addsub_n at WIDTH=8 and WIDTH=16.
module tb_serial_addsub_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        s8_start, s8_sub;
    logic [7:0]  s8_a, s8_b;
    logic [8:0]  s8_res;
    logic        s8_ovf, s8_busy, s8_done;
    logic        s16_start, s16_sub;
    logic [15:0] s16_a, s16_b;
    logic [16:0] s16_res;
    logic        s16_ovf, s16_busy, s16_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub_n #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8_start), .sub_i(s8_sub),
        .a_i(s8_a), .b_i(s8_b), .result_o(s8_res), .overflow_o(s8_ovf),
        .busy_o(s8_busy), .done_o(s8_done)
    );

    serial_addsub_n #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(s16_start), .sub_i(s16_sub),
        .a_i(s16_a), .b_i(s16_b), .result_o(s16_res), .overflow_o(s16_ovf),
        .busy_o(s16_busy), .done_o(s16_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] exp_res, input logic exp_ovf);
        int lat;
        int busy_n;
        logic seen;
        s8_start = 1'b1; s8_sub = sub; s8_a = a; s8_b = b;
        step();
        s8_start = 1'b0; s8_sub = ~sub; s8_a = ~a; s8_b = a;
        lat = 0; busy_n = 0; seen = 1'b0;
        while (!seen && lat < 30) begin
            step();
            lat++;
            if (s8_busy) busy_n++;
            seen = s8_done;
            s8_start = (lat == 4);
        end
        chk({tag, "_latency"}, lat, 32'd9);
        chk({tag, "_busy_cycles"}, busy_n, 32'd8);
        chk({tag, "_result"}, 32'(s8_res), 32'(exp_res));
        chk({tag, "_overflow"}, 32'(s8_ovf), 32'(exp_ovf));
        step();
        chk({tag, "_done_low_after"}, 32'(s8_done), 32'd0);
    endtask

    logic [8:0] stream_res [3] = '{9'h010, 9'h1FF, 9'h080};
    logic       stream_ovf [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int lat;
        logic seen;
        rst = 1'b1;
        s8_start = 1'b0; s8_sub = 1'b0; s8_a = 8'h00; s8_b = 8'h00;
        s16_start = 1'b0; s16_sub = 1'b0; s16_a = 16'h0000; s16_b = 16'h0000;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_idle8", {s8_res, s8_ovf, s8_busy, s8_done}, 32'd0);
        end

        op8("add_200_100", 1'b0, 8'd200, 8'd100, 9'h12C, 1'b0);
        op8("add_100_100", 1'b0, 8'd100, 8'd100, 9'h0C8, 1'b1);
        op8("add_80_80",   1'b0, 8'h80,  8'h80,  9'h100, 1'b1);
        op8("sub_5_7",     1'b1, 8'd5,   8'd7,   9'h1FE, 1'b0);
        op8("sub_80_1",    1'b1, 8'h80,  8'h01,  9'h07F, 1'b1);
        op8("sub_3c_3c",   1'b1, 8'h3C,  8'h3C,  9'h000, 1'b0);

        // Back-to-back: accepting edges at j=0, 9, 18; done after edges 9, 18, 27.
        for (int j = 0; j <= 27; j++) begin
            if (j == 27) begin
                s8_start = 1'b0;
            end else begin
                s8_start = 1'b1;
                case (j)
                    0:       begin s8_sub = 1'b0; s8_a = 8'h0F; s8_b = 8'h01; end
                    9:       begin s8_sub = 1'b1; s8_a = 8'h00; s8_b = 8'h01; end
                    18:      begin s8_sub = 1'b0; s8_a = 8'h7F; s8_b = 8'h01; end
                    default: begin s8_sub = 1'(j); s8_a = 8'(j * 29); s8_b = 8'hC3 ^ 8'(j); end
                endcase
            end
            step();
            chk("stream_done", 32'(s8_done), ((j == 9) || (j == 18) || (j == 27)) ? 32'd1 : 32'd0);
            if ((j == 9) || (j == 18) || (j == 27)) begin
                chk("stream_result", 32'(s8_res), 32'(stream_res[j / 9 - 1]));
                chk("stream_overflow", 32'(s8_ovf), 32'(stream_ovf[j / 9 - 1]));
            end
        end

        s16_start = 1'b1; s16_sub = 1'b0; s16_a = 16'hFFFF; s16_b = 16'h0001;
        step();
        s16_start = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            step();
            lat++;
            seen = s16_done;
        end
        chk("w16_latency", lat, 32'd17);
        chk("w16_result", 32'(s16_res), 32'h0001_0000);
        chk("w16_overflow", 32'(s16_ovf), 32'd0);
        step();

        s16_start = 1'b1; s16_a = 16'h1234; s16_b = 16'h0F0F;
        step();
        s16_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("w16_busy_midop", 32'(s16_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("w16_reset_midop", {s16_res, s16_ovf, s16_busy, s16_done}, 32'd0);
        for (int i = 0; i < 24; i++) begin
            step();
            chk("w16_after_reset", {s16_busy, s16_done}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_addsub_n.md
Name: serial_addsub_n

Overview:
- Parametrised bit-serial adder/subtractor. It is the next generation of the 8-bit serial adder datapath.
- Operates on WIDTH-bit operands, LSB first, one bit per clock.
- Adds a subtract mode, a start/busy/done handshake, a borrow/carry bit and signed-overflow reporting.
- Sits between switch/operand capture logic and the 7-segment display path. The result is held stable for display until the next start.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request: sample operands and begin. Level-sampled and accepted only in IDLE or DONE.
- sub  input  1  mode, sampled with start: 0 = A+B, 1 = A−B.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- result  output  WIDTH+1  [WIDTH-1:0] = sum/difference bits. [WIDTH] = carry-out (add) or borrow (sub, set when a<b unsigned).
- overflow  output  1  two's-complement overflow of the WIDTH-bit result.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result and overflow are valid from this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; result=0, overflow=0, busy=0, done=0. Shift registers, carry and counter are cleared. Reset overrides every other input, including mid-operation; a partial result is discarded.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE/DONE with start=1:
  - Load shA←a.
  - Load shB←b if sub=0, or ~b if sub=1.
  - carry←sub, cnt←WIDTH-1.
  - Clear the result shift register.
  - Next state SHIFT.
- IDLE with start=0: stay IDLE; result and overflow hold.
- SHIFT, every cycle:
  - s = shA[0] ^ shB[0] ^ carry.
  - c = majority(shA[0], shB[0], carry).
  - shA and shB shift right one bit.
  - s shifts into result[WIDTH-1] (the result register shifts right).
  - carry←c, cnt←cnt−1.
- SHIFT, last bit (cnt==0): also capture cin_msb = carry before update (carry into the MSB).
  - result[WIDTH] ← c if mode is add, ~c if mode is sub.
  - overflow ← cin_msb ^ c.
  - Next state DONE.
- start while in SHIFT is ignored. sub, a and b changes during SHIFT have no effect (latched copies are used).
- DONE lasts exactly one cycle, then IDLE, unless start=1 in DONE, which is accepted (back-to-back operation).
- Latency: start accepted at edge k → SHIFT during cycles k+1..k+WIDTH → done=1 in the cycle after edge k+WIDTH+1. That is WIDTH+1 clocks from accepting edge to done.
- Throughput with start held high: one result every WIDTH+1 clocks.
- result and overflow hold their values outside SHIFT. During SHIFT they are not guaranteed meaningful; consumers sample on done.
- Arithmetic is modulo 2^WIDTH on the low bits. Subtraction is A + ~B + 1.

Test Plan:
- WIDTH=8, rst=1 for 2 clocks then rst=0, no start → result=9'h000, overflow=0, busy=0, done=0 indefinitely.
- WIDTH=8, a=200, b=100, sub=0, start 1 clock → busy high 8 cycles. done pulses exactly 9 clocks after the accepting edge with result=9'h12C, overflow=0. done is low the following cycle.
- WIDTH=8, add cases:
  - a=100, b=100 → result=9'h0C8, overflow=1.
  - a=8'h80, b=8'h80 → result=9'h100, overflow=1.
- WIDTH=8, subtract cases:
  - sub=1, a=5, b=7 → result=9'h1FE (borrow=1), overflow=0.
  - sub=1, a=8'h80, b=1 → result=9'h07F, overflow=1.
  - sub=1, a=b=8'h3C → result=9'h000, overflow=0.
- WIDTH=8, start held high continuously with operands changing each cycle → done every 9 clocks. Each result matches the operands present on its accepting edge; start pulses and operand changes during SHIFT are ignored.
- WIDTH=16, a=16'hFFFF, b=1, sub=0 → done 17 clocks after accept, result=17'h10000. Then assert rst mid-operation at bit 5 of a new op → next cycle IDLE, result=0, busy=0, and no done pulse.
